uart_tx_fifo: RTL

//   Buffered 8N1 UART transmitter: the sending end of the serial link whose receive side is the
//   SoC uart_rx_in pin. Used in simulation tops to feed bytes to the SoC; also usable as a

---
 rtl/uart_tx_fifo.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
//   Buffered 8N1 UART transmitter. Bytes written on tx_data/tx_wr are queued in
//   a small FIFO and shifted out LSB first as start(0), 8 data bits, stop(1).
//   Frames leave back-to-back while the FIFO keeps supplying bytes.
//
// Parameters
//   CLKS_PER_BIT  clock cycles per serial bit (>= 2)
//   FIFO_DEPTH    byte FIFO entries (power of two, >= 2)
//
// Ports
//   clk_48mhz    in   system clock, rising edge
//   reset        in   synchronous active-high reset; flushes FIFO, abandons frame
//   tx_data      in   byte to enqueue, sampled when tx_wr=1
//   tx_wr        in   write strobe, one byte per high cycle
//   tx_full      out  FIFO holds FIFO_DEPTH entries
//   tx_empty     out  FIFO holds no entries
//   tx_busy      out  frame in progress (registered)
//   tx_overrun   out  sticky: a write was dropped while full; cleared by reset
//   uart_tx_out  out  serial line, idle high (registered)
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 416,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk_48mhz,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_wr,
  output logic       tx_full,
  output logic       tx_empty,
  output logic       tx_busy,
  output logic       tx_overrun,
  output logic       uart_tx_out
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST  = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] COUNT_FULL = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  // FIFO storage and bookkeeping
  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic [CW-1:0] count_next;
  logic          overrun_reg;
  logic          wr_en;
  logic          pop_en;

  // Serializer
  state_t        state_reg;
  logic [BW-1:0] baud_reg;
  logic [2:0]    bit_reg;
  logic [7:0]    shift_reg;
  logic          line_reg;
  logic          busy_reg;
  logic          baud_last;

  assign tx_full     = (count_reg == COUNT_FULL);
  assign tx_empty    = (count_reg == '0);
  assign tx_overrun  = overrun_reg;
  assign tx_busy     = busy_reg;
  assign uart_tx_out = line_reg;

  assign baud_last = (baud_reg == BAUD_LAST);

  // A write is accepted only when the FIFO is not full at the start of the
  // cycle; a pop in the same cycle does not rescue a write against a full FIFO.
  assign wr_en = tx_wr && !tx_full;

  // Pop from IDLE as soon as data is present, or on the final stop-bit cycle
  // so the next start bit follows with no idle gap.
  assign pop_en = !tx_empty &&
                  ((state_reg == IDLE) || ((state_reg == STOP) && baud_last));

  always_comb begin
    count_next = count_reg;
    if (wr_en && !pop_en) begin
      count_next = count_reg + CW'(1);
    end else if (!wr_en && pop_en) begin
      count_next = count_reg - CW'(1);
    end
  end

  // Storage has no reset so it can map onto distributed/block RAM; the
  // pointers and count alone define what is valid.
  always_ff @(posedge clk_48mhz) begin
    if (wr_en) begin
      fifo_mem[wr_ptr_reg] <= tx_data;
    end
  end

  always_ff @(posedge clk_48mhz) begin
    if (reset) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      count_reg   <= '0;
      overrun_reg <= 1'b0;
    end else begin
      count_reg <= count_next;
      if (wr_en) begin
        wr_ptr_reg <= wr_ptr_reg + PW'(1);
      end
      if (pop_en) begin
        rd_ptr_reg <= rd_ptr_reg + PW'(1);
      end
      if (tx_wr && tx_full) begin
        overrun_reg <= 1'b1;
      end
    end
  end

  // Serializer FSM. The line and busy outputs are registered images of the
  // current state, so they trail the state register by one cycle: a pop at
  // edge E+1 shows as a low line and busy=1 at E+2, and every bit still lasts
  // exactly CLKS_PER_BIT cycles on the pin.
  always_ff @(posedge clk_48mhz) begin
    if (reset) begin
      state_reg <= IDLE;
      baud_reg  <= '0;
      bit_reg   <= '0;
      shift_reg <= '0;
      line_reg  <= 1'b1;
      busy_reg  <= 1'b0;
    end else begin
      busy_reg <= (state_reg != IDLE);

      case (state_reg)
        START:   line_reg <= 1'b0;
        DATA:    line_reg <= shift_reg[0];
        default: line_reg <= 1'b1;
      endcase

      case (state_reg)
        IDLE: begin
          if (pop_en) begin
            shift_reg <= fifo_mem[rd_ptr_reg];
            baud_reg  <= '0;
            state_reg <= START;
          end
        end

        START: begin
          if (baud_last) begin
            baud_reg  <= '0;
            bit_reg   <= '0;
            state_reg <= DATA;
          end else begin
            baud_reg <= baud_reg + BW'(1);
          end
        end

        DATA: begin
          if (baud_last) begin
            baud_reg  <= '0;
            shift_reg <= {1'b0, shift_reg[7:1]};
            if (bit_reg == 3'd7) begin
              state_reg <= STOP;
            end else begin
              bit_reg <= bit_reg + 3'd1;
            end
          end else begin
            baud_reg <= baud_reg + BW'(1);
          end
        end

        STOP: begin
          if (baud_last) begin
            baud_reg <= '0;
            if (pop_en) begin
              shift_reg <= fifo_mem[rd_ptr_reg];
              state_reg <= START;
            end else begin
              state_reg <= IDLE;
            end
          end else begin
            baud_reg <= baud_reg + BW'(1);
          end
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
